batch_norm_stream: RTL
======================

Name: batch_norm_stream

Overview:
- Streaming, pipelined batch-normalization engine for the CNN datapath.
- Successor to the fully parallel per-element array. Processes LANES elements per beat from a channel-major feature-map stream.
- Holds per-channel parameters (gamma, moving mean, inverse std, beta) in internal registers loaded through a write port.
- Adds valid/ready backpressure, channel/frame tracking, saturation and optional ReLU. Sits between a conv layer output and the next layer's input buffer.

Parameters:
- DATA_WIDTH, 16, signed fixed-point element width.
- FRAC_BITS, 8, fractional bits of the data and all parameters.
- FILTERS, 64, number of channels per frame.
- INPUT, 30, feature-map side; each channel has INPUT*INPUT elements.
- LANES, 4, elements per beat; must divide INPUT*INPUT. BEATS = INPUT*INPUT/LANES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- relu_en_i  in  1  1 = clamp negative results to 0; sampled per beat at input acceptance
- param_we_i  in  1  parameter write strobe
- param_addr_i  in  clog2(FILTERS)  channel index to write
- param_gamma_i  in  DATA_WIDTH  gamma
- param_mean_i  in  DATA_WIDTH  moving mean
- param_inv_std_i  in  DATA_WIDTH  1/sqrt(var+eps), precomputed
- param_beta_i  in  DATA_WIDTH  beta
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input beat accepted when valid&ready
- s_data_i  in  LANES*DATA_WIDTH  lane k at [k*DATA_WIDTH+:DATA_WIDTH]
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  LANES*DATA_WIDTH  normalized lanes
- m_channel_o  out  clog2(FILTERS)  channel of output beat
- m_last_o  out  1  last beat of frame (channel FILTERS-1, beat BEATS-1)
- busy_o  out  1  any pipeline stage valid or frame partially received

Behaviour:
- Reset: all counters 0; all stage valids 0; m_valid_o=0, m_data_o=0, m_channel_o=0, m_last_o=0, busy_o=0; s_ready_o=1 after reset.
- Parameter registers reset to identity: gamma=1.0 (1<<FRAC_BITS), mean=0, inv_std=1.0, beta=0.
- Param write: on param_we_i, the addressed channel's four registers update at the clock edge. Out-of-range address is ignored. Beats accepted in a later cycle see the new values; a beat accepted in the same cycle sees the old values.
- Counters: beat_cnt 0..BEATS-1 and ch_cnt 0..FILTERS-1 advance only on input acceptance. beat_cnt wraps to 0 and increments ch_cnt; ch_cnt wraps to 0 after FILTERS-1 (frame end, next frame starts immediately).
- Pipeline: 3 stages; all stages advance when en = !m_valid_o | m_ready_i. s_ready_o = en. No bubbles under continuous flow.
  - S1: capture lanes, channel, last flag, relu_en, and the channel's params. d = x - mean, DATA_WIDTH+1 bits.
  - S2: p = (d * inv_std) >>> FRAC_BITS, arithmetic shift (floor), full width kept.
  - S3: q = ((p * gamma) >>> FRAC_BITS) + beta. Saturate to [-2^(DW-1), 2^(DW-1)-1]. Then ReLU if the beat's relu_en is set. Register to m_data_o.
- Latency: 3 cycles from acceptance to m_valid_o with no backpressure.
- Backpressure: while m_valid_o & !m_ready_i, all stage registers and outputs hold stable and s_ready_o=0.
- Simultaneous accept at input and output: both happen; counters advance.
- busy_o = any stage valid | beat_cnt!=0 | ch_cnt!=0.
- Reset mid-frame: pipeline contents are discarded and counters restart at channel 0. Parameter registers return to identity.

Decomposition:
- Shared package: FRAC_BITS default, a saturate function, and a fixed-point multiply-shift helper.
- Sub-module bn_lane_datapath, instantiated LANES times: the 3-stage arithmetic for one element, with a shared enable. Control (counters, valids, params, flags) stays in the top.

Test Plan:
- Config DW=16, FRAC=8. Identity after reset: x=0x0300 -> out 0x0300 after 3 cycles, m_channel_o=0.
- Arithmetic: write ch0 mean=0x0100, inv_std=0x0080, gamma=0x0200, beta=0x0040; x=0x0300 -> 0x0240. Same parameters with x=0x0000 -> 0xFF40.
- Saturation/ReLU: mean=0x8100, inv_std=0x0100, gamma=0x0400, x=0x7F00 -> 0x7FFF. Same channel with x=0x8000, mean=0x7F00 -> 0x8000 with relu_en_i=0, and 0x0000 with relu_en_i=1.
- Framing: FILTERS=2, INPUT=2, LANES=2, 8 back-to-back beats -> m_channel_o 0,0,1,1,0,0,1,1; m_last_o on beats 4 and 8; no gaps.
- Backpressure: hold m_ready_i=0 for 5 cycles mid-stream -> m_data_o stable, s_ready_o=0, no beats lost or duplicated against the reference model; random m_ready_i for 1000 beats matches the model.
- Reset mid-frame: assert rst after 3 beats -> outputs 0, busy_o=0; next beat is tagged channel 0 and uses identity params.

Source files
------------

// File: rtl/batch_norm_stream_pkg.sv
// rtl/batch_norm_stream_pkg.sv - shared constants and fixed-point helpers for batch_norm_stream
package batch_norm_stream_pkg;

   localparam int FRAC_BITS_DEF = 8;
   localparam int CALC_W        = 64;

   // Wide signed multiply followed by an arithmetic (flooring) right shift.
   function automatic logic signed [CALC_W-1:0] bn_mul_shift(
      input logic signed [CALC_W-1:0] a,
      input logic signed [CALC_W-1:0] b,
      input int                       frac
   );
      logic signed [CALC_W-1:0] prod;
      prod = a * b;
      return prod >>> frac;
   endfunction

   function automatic logic signed [CALC_W-1:0] bn_saturate(
      input logic signed [CALC_W-1:0] v,
      input int                       dw
   );
      logic signed [CALC_W-1:0] hi;
      logic signed [CALC_W-1:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/batch_norm_stream_lane.sv
// rtl/batch_norm_stream_lane.sv - three-stage normalize arithmetic for one element
// Stage control and per-channel parameters are supplied by the top, aligned to each stage.
module bn_lane_datapath
   import batch_norm_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_en,
   input  logic signed [DATA_WIDTH-1:0] i_x,
   input  logic signed [DATA_WIDTH-1:0] i_mean,
   input  logic signed [DATA_WIDTH-1:0] i_inv_std,
   input  logic signed [DATA_WIDTH-1:0] i_gamma,
   input  logic signed [DATA_WIDTH-1:0] i_beta,
   input  logic                         i_relu,
   output logic        [DATA_WIDTH-1:0] o_y
);

   localparam int DW1 = DATA_WIDTH + 1;
   localparam int PW  = 2 * DATA_WIDTH + 1;

   logic signed [DW1-1:0]        r_d;
   logic signed [PW-1:0]         r_p;
   logic        [DATA_WIDTH-1:0] r_y;
   logic signed [CALC_W-1:0]     w_q;
   logic        [DATA_WIDTH-1:0] w_sat;

   assign w_q   = bn_mul_shift(CALC_W'(r_p), CALC_W'(i_gamma), FRAC_BITS) + CALC_W'(i_beta);
   assign w_sat = DATA_WIDTH'(bn_saturate(w_q, DATA_WIDTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d <= '0;
         r_p <= '0;
         r_y <= '0;
      end else if (i_en) begin
         r_d <= DW1'(i_x) - DW1'(i_mean);
         r_p <= PW'(bn_mul_shift(CALC_W'(r_d), CALC_W'(i_inv_std), FRAC_BITS));
         r_y <= (i_relu && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/batch_norm_stream.sv
// rtl/batch_norm_stream.sv - streaming batch-normalization engine, LANES elements per beat
// Owns framing counters, per-channel parameter registers and the stage valid/flag pipeline.
module batch_norm_stream
   import batch_norm_stream_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int FRAC_BITS  = FRAC_BITS_DEF,
   parameter  int FILTERS    = 64,
   parameter  int INPUT      = 30,
   parameter  int LANES      = 4,
   localparam int CW         = (FILTERS > 1) ? $clog2(FILTERS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          relu_en_i,
   input  logic                          param_we_i,
   input  logic [CW-1:0]                 param_addr_i,
   input  logic [DATA_WIDTH-1:0]         param_gamma_i,
   input  logic [DATA_WIDTH-1:0]         param_mean_i,
   input  logic [DATA_WIDTH-1:0]         param_inv_std_i,
   input  logic [DATA_WIDTH-1:0]         param_beta_i,
   input  logic                          s_valid_i,
   output logic                          s_ready_o,
   input  logic [LANES*DATA_WIDTH-1:0]   s_data_i,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic [LANES*DATA_WIDTH-1:0]   m_data_o,
   output logic [CW-1:0]                 m_channel_o,
   output logic                          m_last_o,
   output logic                          busy_o
);

   localparam int BEATS = INPUT * INPUT / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRAC_BITS;

   logic [DATA_WIDTH-1:0] r_gamma   [FILTERS];
   logic [DATA_WIDTH-1:0] r_mean    [FILTERS];
   logic [DATA_WIDTH-1:0] r_inv_std [FILTERS];
   logic [DATA_WIDTH-1:0] r_beta    [FILTERS];

   logic [BW-1:0]         r_beat_cnt;
   logic [CW-1:0]         r_ch_cnt;

   logic                  r_s1_valid, r_s1_last, r_s1_relu;
   logic [CW-1:0]         r_s1_ch;
   logic [DATA_WIDTH-1:0] r_s1_inv_std, r_s1_gamma, r_s1_beta;
   logic                  r_s2_valid, r_s2_last, r_s2_relu;
   logic [CW-1:0]         r_s2_ch;
   logic [DATA_WIDTH-1:0] r_s2_gamma, r_s2_beta;
   logic                  r_m_valid, r_m_last;
   logic [CW-1:0]         r_m_channel;

   logic                  w_en, w_acc, w_beat_last, w_ch_last, w_addr_ok;
   logic [DATA_WIDTH-1:0] w_mean;

   assign w_en        = !r_m_valid || m_ready_i;
   assign w_acc       = s_valid_i && w_en;
   assign w_beat_last = (r_beat_cnt == BW'(BEATS - 1));
   assign w_ch_last   = (r_ch_cnt == CW'(FILTERS - 1));
   assign w_addr_ok   = ({1'b0, param_addr_i} < (CW + 1)'(FILTERS));
   assign w_mean      = r_mean[r_ch_cnt];

   // A beat accepted in the write cycle reads the pre-write values: the write lands at the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < FILTERS; c++) begin
            r_gamma[c]   <= ONE;
            r_mean[c]    <= '0;
            r_inv_std[c] <= ONE;
            r_beta[c]    <= '0;
         end
      end else if (param_we_i && w_addr_ok) begin
         r_gamma[param_addr_i]   <= param_gamma_i;
         r_mean[param_addr_i]    <= param_mean_i;
         r_inv_std[param_addr_i] <= param_inv_std_i;
         r_beta[param_addr_i]    <= param_beta_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat_cnt <= '0;
         r_ch_cnt   <= '0;
      end else if (w_acc) begin
         if (w_beat_last) begin
            r_beat_cnt <= '0;
            r_ch_cnt   <= w_ch_last ? '0 : r_ch_cnt + 1'b1;
         end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_last    <= 1'b0;
         r_s1_relu    <= 1'b0;
         r_s1_ch      <= '0;
         r_s1_inv_std <= '0;
         r_s1_gamma   <= '0;
         r_s1_beta    <= '0;
         r_s2_valid   <= 1'b0;
         r_s2_last    <= 1'b0;
         r_s2_relu    <= 1'b0;
         r_s2_ch      <= '0;
         r_s2_gamma   <= '0;
         r_s2_beta    <= '0;
         r_m_valid    <= 1'b0;
         r_m_last     <= 1'b0;
         r_m_channel  <= '0;
      end else if (w_en) begin
         r_s1_valid   <= s_valid_i;
         r_s1_last    <= w_beat_last && w_ch_last;
         r_s1_relu    <= relu_en_i;
         r_s1_ch      <= r_ch_cnt;
         r_s1_inv_std <= r_inv_std[r_ch_cnt];
         r_s1_gamma   <= r_gamma[r_ch_cnt];
         r_s1_beta    <= r_beta[r_ch_cnt];
         r_s2_valid   <= r_s1_valid;
         r_s2_last    <= r_s1_last;
         r_s2_relu    <= r_s1_relu;
         r_s2_ch      <= r_s1_ch;
         r_s2_gamma   <= r_s1_gamma;
         r_s2_beta    <= r_s1_beta;
         r_m_valid    <= r_s2_valid;
         r_m_last     <= r_s2_last;
         r_m_channel  <= r_s2_ch;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bn_lane_datapath #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS)
      ) u_dp (
         .clk       (clk),
         .rst       (rst),
         .i_en      (w_en),
         .i_x       (s_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
         .i_mean    (w_mean),
         .i_inv_std (r_s1_inv_std),
         .i_gamma   (r_s2_gamma),
         .i_beta    (r_s2_beta),
         .i_relu    (r_s2_relu),
         .o_y       (m_data_o[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign s_ready_o   = w_en;
   assign m_valid_o   = r_m_valid;
   assign m_last_o    = r_m_last;
   assign m_channel_o = r_m_channel;
   assign busy_o      = r_s1_valid || r_s2_valid || r_m_valid || (r_beat_cnt != '0) || (r_ch_cnt != '0);

endmodule
